// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit-select mux between 8 requesters.
// Registered sel/grant/hold_cnt outputs with a bounded per-grant hold time.
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       req,
    output logic [2:0]       sel,
    output logic [7:0]       grant,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [2:0]       sel_n;
    logic [7:0]       grant_n;
    logic             gnt_valid_n;
    logic [CNT_W-1:0] hold_cnt_n;

    logic [2:0]       owner_next;
    logic [2:0]       pick_idle;
    logic [2:0]       pick_rel;
    logic             release_now;

    // First requester at or after start, wrapping mod 8
    function automatic logic [2:0] pick_from(input logic [2:0] start, input logic [7:0] r);
        logic [2:0] result;
        logic       found;
        result = start;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = start + i[2:0];
            if (!found && r[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign owner_next  = sel + 3'd1;
    assign pick_idle   = pick_from(ptr, req);
    assign pick_rel    = pick_from(owner_next, req);
    assign release_now = !req[sel] ||
                         ((MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD)));

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        sel_n       = sel;
        grant_n     = grant;
        gnt_valid_n = gnt_valid;
        hold_cnt_n  = hold_cnt;

        case (state)
            IDLE: begin
                grant_n     = 8'h00;
                gnt_valid_n = 1'b0;
                hold_cnt_n  = '0;
                if (en && |req) begin
                    state_n     = GRANT;
                    sel_n       = pick_idle;
                    grant_n     = 8'h01 << pick_idle;
                    gnt_valid_n = 1'b1;
                    hold_cnt_n  = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!en) begin
                    // Owner forfeits its turn when arbitration is disabled
                    state_n     = IDLE;
                    ptr_n       = owner_next;
                    grant_n     = 8'h00;
                    gnt_valid_n = 1'b0;
                    hold_cnt_n  = '0;
                end else if (release_now) begin
                    ptr_n = owner_next;
                    if (|req) begin
                        sel_n       = pick_rel;
                        grant_n     = 8'h01 << pick_rel;
                        gnt_valid_n = 1'b1;
                        hold_cnt_n  = CNT_W'(1);
                    end else begin
                        state_n     = IDLE;
                        grant_n     = 8'h00;
                        gnt_valid_n = 1'b0;
                        hold_cnt_n  = '0;
                    end
                end else if (hold_cnt != '1) begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n     = IDLE;
                grant_n     = 8'h00;
                gnt_valid_n = 1'b0;
                hold_cnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            sel       <= 3'd0;
            grant     <= 8'h00;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            sel       <= sel_n;
            grant     <= grant_n;
            gnt_valid <= gnt_valid_n;
            hold_cnt  <= hold_cnt_n;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: a vector table plus hand sequences, with expected
// outputs queued when a stimulus is driven and compared after the next edge.
module tb_mux8_rr_arbiter;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] grant;
        logic       gnt_valid;
        logic [2:0] hold_cnt;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [7:0] req;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       gnt_valid;
    logic [2:0] hold_cnt;

    int   checks = 0;
    int   errors = 0;
    out_t sb_q[$];
    vec_t vectors[22];

    mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .sel       (sel),
        .grant     (grant),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    function automatic out_t mk_out(input logic [2:0] s, input logic [7:0] g, input logic [2:0] h);
        out_t o;
        o.sel       = s;
        o.grant     = g;
        o.gnt_valid = (g != 8'h00);
        o.hold_cnt  = h;
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic r, input logic e, input logic [7:0] q,
                                    input logic [2:0] s, input logic [7:0] g, input logic [2:0] h);
        vec_t v;
        v.rst = r;
        v.en  = e;
        v.req = q;
        v.exp = mk_out(s, g, h);
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] q, input out_t exp);
        rst = r;
        en  = e;
        req = q;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        out_t exp;
        out_t act;
        if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", name);
            return;
        end
        exp = sb_q.pop_front();
        act.sel       = sel;
        act.grant     = grant;
        act.gnt_valid = gnt_valid;
        act.hold_cnt  = hold_cnt;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got sel=%0d grant=%h valid=%b hold=%0d, want sel=%0d grant=%h valid=%b hold=%0d",
                     name, act.sel, act.grant, act.gnt_valid, act.hold_cnt,
                     exp.sel, exp.grant, exp.gnt_valid, exp.hold_cnt);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] q, input out_t exp, input string name);
        applyStimulus(r, e, q, exp);
        checkOutput(name);
    endtask

    initial begin
        vectors[0]  = mk_vec(1, 1, 8'hFF, 3'd0, 8'h00, 3'd0);
        vectors[1]  = mk_vec(1, 0, 8'h00, 3'd0, 8'h00, 3'd0);
        vectors[2]  = mk_vec(0, 1, 8'h00, 3'd0, 8'h00, 3'd0);
        vectors[3]  = mk_vec(0, 1, 8'h00, 3'd0, 8'h00, 3'd0);
        vectors[4]  = mk_vec(0, 1, 8'h10, 3'd4, 8'h10, 3'd1);
        vectors[5]  = mk_vec(0, 1, 8'h00, 3'd4, 8'h00, 3'd0);
        vectors[6]  = mk_vec(0, 1, 8'h04, 3'd2, 8'h04, 3'd1);
        vectors[7]  = mk_vec(0, 1, 8'h05, 3'd2, 8'h04, 3'd2);
        vectors[8]  = mk_vec(0, 1, 8'h01, 3'd0, 8'h01, 3'd1);
        vectors[9]  = mk_vec(0, 1, 8'h01, 3'd0, 8'h01, 3'd2);
        vectors[10] = mk_vec(0, 0, 8'h01, 3'd0, 8'h00, 3'd0);
        vectors[11] = mk_vec(0, 1, 8'h01, 3'd0, 8'h01, 3'd1);
        vectors[12] = mk_vec(0, 1, 8'h03, 3'd0, 8'h01, 3'd2);
        vectors[13] = mk_vec(0, 1, 8'h03, 3'd0, 8'h01, 3'd3);
        vectors[14] = mk_vec(0, 1, 8'h03, 3'd0, 8'h01, 3'd4);
        vectors[15] = mk_vec(0, 1, 8'h03, 3'd1, 8'h02, 3'd1);
        vectors[16] = mk_vec(0, 1, 8'h01, 3'd0, 8'h01, 3'd1);
        vectors[17] = mk_vec(1, 1, 8'hFF, 3'd0, 8'h00, 3'd0);
        vectors[18] = mk_vec(0, 0, 8'hFF, 3'd0, 8'h00, 3'd0);
        vectors[19] = mk_vec(0, 1, 8'h80, 3'd7, 8'h80, 3'd1);
        vectors[20] = mk_vec(0, 1, 8'h80, 3'd7, 8'h80, 3'd2);
        vectors[21] = mk_vec(0, 1, 8'h00, 3'd7, 8'h00, 3'd0);

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            step(vectors[i].rst, vectors[i].en, vectors[i].req, vectors[i].exp,
                 $sformatf("vec%0d", i));
        end

        // Fairness: all eight requesting, each owner held exactly 4 cycles, wrapping 7->0
        step(1, 1, 8'hFF, mk_out(3'd0, 8'h00, 3'd0), "rr_reset0");
        step(1, 1, 8'hFF, mk_out(3'd0, 8'h00, 3'd0), "rr_reset1");
        for (int k = 0; k < 40; k++) begin
            logic [2:0] o;
            o = 3'((k / 4) % 8);
            step(0, 1, 8'hFF, mk_out(o, 8'h01 << o, 3'((k % 4) + 1)), $sformatf("rr_k%0d", k));
        end

        // Lone requester 6 keeps being re-granted at each expiry
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 8'h40, mk_out(3'd6, 8'h40, 3'((k % 4) + 1)), $sformatf("solo6_k%0d", k));
        end

        // Reset while owner 5 holds the mux
        step(1, 1, 8'hFF, mk_out(3'd0, 8'h00, 3'd0), "mid_reset0");
        step(1, 1, 8'hFF, mk_out(3'd0, 8'h00, 3'd0), "mid_reset1");
        for (int k = 0; k < 21; k++) begin
            logic [2:0] o;
            o = 3'((k / 4) % 8);
            step(0, 1, 8'hFF, mk_out(o, 8'h01 << o, 3'((k % 4) + 1)), $sformatf("pre5_k%0d", k));
        end
        step(1, 1, 8'hFF, mk_out(3'd0, 8'h00, 3'd0), "rst_during5");
        step(0, 1, 8'hFF, mk_out(3'd0, 8'h01, 3'd1), "after_rst5");

        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
